bht_update_scheduler: RTL

Controller that sequences the shared two-bit-counter branch history table (BHT). It sits between the fetch stage (prediction lookups) and the commit stage (taken/not-taken feedback). After reset and on flush, it sweeps every table entry to its initial state. It then arbitrates the table's single access slot per cycle between lookups and buffered updates, using a small update FIFO and a starvation guard.

---
 rtl/bp_pkg.sv | 17 +
 rtl/bht_update_scheduler_if.sv | 27 ++
 rtl/bht_update_fifo.sv | 65 ++++++
 rtl/bht_update_scheduler.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: scheduler FSM states and two-bit
// counter encodings used by the branch history table.
package bp_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  // Two-bit saturating counter encodings; entries are swept to CTR_INIT.
  localparam logic [1:0] CTR_SNT  = 2'b00;
  localparam logic [1:0] CTR_WNT  = 2'b01;
  localparam logic [1:0] CTR_WT   = 2'b10;
  localparam logic [1:0] CTR_ST   = 2'b11;
  localparam logic [1:0] CTR_INIT = CTR_WNT;

endpackage

// File: rtl/bht_update_scheduler_if.sv
// Fetch/commit side of the BHT scheduler: lookup request, prediction result
// and update feedback handshakes.
interface bht_update_scheduler_if #(
  parameter int INDEX_W = 8
);

  logic               lookup_valid;
  logic [INDEX_W-1:0] lookup_index;
  logic               lookup_ready;
  logic               pred_valid;
  logic               pred_taken;
  logic               upd_valid;
  logic [INDEX_W-1:0] upd_index;
  logic               upd_taken;
  logic               upd_ready;

  modport master (
    output lookup_valid, lookup_index, upd_valid, upd_index, upd_taken,
    input  lookup_ready, pred_valid, pred_taken, upd_ready
  );

  modport slave (
    input  lookup_valid, lookup_index, upd_valid, upd_index, upd_taken,
    output lookup_ready, pred_valid, pred_taken, upd_ready
  );

endinterface

// File: rtl/bht_update_fifo.sv
// Small synchronous FIFO buffering {index, taken} branch feedback until the
// scheduler finds a free table slot. clear empties it in one cycle.
module bht_update_fifo #(
  parameter int INDEX_W = 8,
  parameter int QDEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic [INDEX_W-1:0] push_index,
  input  logic               push_taken,
  input  logic               pop,
  output logic [INDEX_W-1:0] head_index,
  output logic               head_taken,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QDEPTH);

  logic [INDEX_W:0]   mem_r [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  // Overflow/underflow requests are dropped rather than corrupting pointers.
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= {push_index, push_taken};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_index = mem_r[rd_ptr_r][INDEX_W:1];
  assign head_taken = mem_r[rd_ptr_r][0];
  assign full       = (count_r == DEPTH_CNT);
  assign empty      = (count_r == '0);

endmodule

// File: rtl/bht_update_scheduler.sv
// Sequences the shared BHT access slot: init sweep after reset/flush, then
// per-cycle arbitration between fetch lookups and buffered commit updates.
module bht_update_scheduler
  import bp_pkg::*;
#(
  parameter int INDEX_W    = 8,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  bht_update_scheduler_if.slave bus,
  output logic                  tbl_get,
  output logic [INDEX_W-1:0]    tbl_get_index,
  input  logic                  tbl_prediction,
  output logic                  tbl_set,
  output logic [INDEX_W-1:0]    tbl_set_index,
  output logic                  tbl_feedback,
  output logic                  tbl_reset,
  output logic [INDEX_W-1:0]    tbl_reset_index,
  output logic                  init_done
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]    STARVE_LIMIT = SC_W'(STARVE_MAX);
  localparam logic [INDEX_W-1:0] LAST_IDX     = '1;

  sched_state_t       state_r;
  sched_state_t       state_s;
  logic [INDEX_W-1:0] init_idx_r;
  logic [INDEX_W-1:0] init_idx_s;
  logic [SC_W-1:0]    starve_cnt_r;
  logic [SC_W-1:0]    starve_cnt_s;
  logic               pred_valid_r;
  logic               pred_taken_r;

  logic               lookup_grant_s;
  logic               drain_s;
  logic               upd_ready_s;
  logic               push_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [INDEX_W-1:0] head_index_s;
  logic               head_taken_s;

  bht_update_fifo #(
    .INDEX_W (INDEX_W),
    .QDEPTH  (QDEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .push       (push_s),
    .push_index (bus.upd_index),
    .push_taken (bus.upd_taken),
    .pop        (drain_s),
    .head_index (head_index_s),
    .head_taken (head_taken_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  // Next-state, arbitration and starvation accounting; reset/flush mask every strobe.
  always_comb begin
    state_s         = state_r;
    init_idx_s      = init_idx_r;
    starve_cnt_s    = starve_cnt_r;
    lookup_grant_s  = 1'b0;
    drain_s         = 1'b0;
    tbl_reset       = 1'b0;
    tbl_reset_index = '0;
    if (reset || flush) begin
      state_s      = INIT;
      init_idx_s   = '0;
      starve_cnt_s = '0;
    end else begin
      case (state_r)
        INIT: begin
          tbl_reset       = 1'b1;
          tbl_reset_index = init_idx_r;
          init_idx_s      = init_idx_r + INDEX_W'(1);
          if (init_idx_r == LAST_IDX) begin
            state_s = RUN;
          end else begin
            state_s = INIT;
          end
        end
        RUN: begin
          if (fifo_full_s) begin
            drain_s = 1'b1;
          end else if (!fifo_empty_s && (starve_cnt_r == STARVE_LIMIT)) begin
            drain_s = 1'b1;
          end else if (bus.lookup_valid) begin
            lookup_grant_s = 1'b1;
          end else if (!fifo_empty_s) begin
            drain_s = 1'b1;
          end else begin
            drain_s        = 1'b0;
            lookup_grant_s = 1'b0;
          end
          // Only lookups that bypass a waiting update count toward starvation.
          if (drain_s || fifo_empty_s) begin
            starve_cnt_s = '0;
          end else if (lookup_grant_s && (starve_cnt_r != STARVE_LIMIT)) begin
            starve_cnt_s = starve_cnt_r + SC_W'(1);
          end else begin
            starve_cnt_s = starve_cnt_r;
          end
        end
        default: begin
          state_s    = INIT;
          init_idx_s = '0;
        end
      endcase
    end
  end

  // State, sweep index, starvation counter and one-cycle prediction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= INIT;
      init_idx_r   <= '0;
      starve_cnt_r <= '0;
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      init_idx_r   <= init_idx_s;
      starve_cnt_r <= starve_cnt_s;
      pred_valid_r <= lookup_grant_s;
      pred_taken_r <= lookup_grant_s & tbl_prediction;
    end
  end

  assign upd_ready_s      = !fifo_full_s && !flush;
  assign push_s           = bus.upd_valid && upd_ready_s;

  assign bus.lookup_ready = lookup_grant_s;
  assign bus.upd_ready    = upd_ready_s;
  assign bus.pred_valid   = pred_valid_r;
  assign bus.pred_taken   = pred_taken_r;

  assign tbl_get          = lookup_grant_s;
  assign tbl_get_index    = lookup_grant_s ? bus.lookup_index : '0;
  assign tbl_set          = drain_s;
  assign tbl_set_index    = drain_s ? head_index_s : '0;
  assign tbl_feedback     = drain_s & head_taken_s;
  assign init_done        = (state_r == RUN);

endmodule
